hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl.sv | 94 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle multiply hold-off and taken-branch flush.
// Control outputs respond combinationally in the same cycle; FSM, busy counter and stall counter are registered.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int RA_W    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_is_mul,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_reg_write,
  input  logic            branch_taken,
  output logic            stall,
  output logic            pc_we,
  output logic            if_id_we,
  output logic            flush,
  output logic [3:0]      busy_cnt,
  output logic [15:0]     stall_events
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [3:0] cnt_nxt;
  logic       lu;

  assign lu = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // Reset gates the outputs directly so X on the inputs never reaches them.
  always_comb begin
    stall     = 1'b0;
    flush     = 1'b0;
    pc_we     = 1'b1;
    if_id_we  = 1'b1;
    state_nxt = state;
    cnt_nxt   = busy_cnt;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            flush = 1'b1;
          end else if (lu) begin
            stall    = 1'b1;
            pc_we    = 1'b0;
            if_id_we = 1'b0;
          end else if (id_is_mul) begin
            state_nxt = MUL_BUSY;
            cnt_nxt   = MUL_LOAD;
          end
        end
        MUL_BUSY: begin
          stall    = 1'b1;
          pc_we    = 1'b0;
          if_id_we = 1'b0;
          // branch_taken is deliberately ignored here: it cannot legally arrive behind a multiply.
          if (busy_cnt <= 4'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = busy_cnt - 4'd1;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      busy_cnt     <= 4'd0;
      stall_events <= 16'd0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= cnt_nxt;
      if (stall && (stall_events != 16'hFFFF)) begin
        stall_events <= stall_events + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a cycle-count reference model.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;
  localparam int MUL_LAT = 3;
  localparam int RA_W    = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, id_is_mul;
  logic            ex_mem_read, ex_reg_write, branch_taken;
  logic            stall, pc_we, if_id_we, flush;
  logic [3:0]      busy_cnt;
  logic [15:0]     stall_events;

  int total = 0;
  int bad   = 0;
  int protocol_errs = 0;

  // Reference model: number of multiply stall cycles still owed, and stall count.
  int m_busy   = 0;
  int m_events = 0;
  int n_busy, n_events;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_mul(id_is_mul), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .branch_taken(branch_taken),
    .stall(stall), .pc_we(pc_we), .if_id_we(if_id_we), .flush(flush),
    .busy_cnt(busy_cnt), .stall_events(stall_events)
  );

  function automatic bit model_lu();
    return ex_mem_read && ex_reg_write && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  task automatic model_outputs(output logic s, output logic f, output logic p, output logic i);
    s = 1'b0; f = 1'b0; p = 1'b1; i = 1'b1;
    if (rst_n) begin
      if (m_busy > 0) begin
        s = 1'b1; p = 1'b0; i = 1'b0;
      end else if (branch_taken) begin
        f = 1'b1;
      end else if (model_lu()) begin
        s = 1'b1; p = 1'b0; i = 1'b0;
      end
    end
  endtask

  // Computes the model's state after the coming edge from the current inputs.
  task automatic model_next();
    logic s, f, p, i;
    model_outputs(s, f, p, i);
    if (m_busy > 0)                                    n_busy = m_busy - 1;
    else if (!branch_taken && !model_lu() && id_is_mul) n_busy = MUL_LAT - 1;
    else                                               n_busy = 0;
    n_events = (s && m_events < 65535) ? m_events + 1 : m_events;
  endtask

  task automatic drive_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_is_mul = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic drive_lu(input logic [RA_W-1:0] rd);
    drive_idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    id_use_rs2 = 1'b1; id_rs2 = 3'd3;
  endtask

  // Leaves the bench at posedge+1 with reset released and the model cleared.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    m_busy = 0; m_events = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    id_rs1 = 'x; id_rs2 = 'x; ex_rd = 'x; id_use_rs1 = 1'bx; id_use_rs2 = 1'bx;
    id_is_mul = 1'bx; ex_mem_read = 1'bx; ex_reg_write = 1'bx; branch_taken = 1'bx;
    #1;
    total++;
    if ({stall, flush, pc_we, if_id_we} !== 4'b0011) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0011", {stall, flush, pc_we, if_id_we});
    end
    @(posedge clk); #1;
    total++;
    if (busy_cnt !== 4'd0 || stall_events !== 16'd0) begin
      bad++; $display("FAIL reset_regs: busy_cnt=%0d stall_events=%0d want 0/0", busy_cnt, stall_events);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    drive_lu(3'd3);
    #3;
    total++;
    if ({stall, pc_we, if_id_we, flush} !== 4'b1000) begin
      bad++; $display("FAIL lu_stall: got %b want 1000", {stall, pc_we, if_id_we, flush});
    end
    @(posedge clk); #1;
    drive_idle();
    #3;
    total++;
    if ({stall, pc_we, if_id_we} !== 3'b011) begin
      bad++; $display("FAIL lu_release: got %b want 011", {stall, pc_we, if_id_we});
    end
    total++;
    if (stall_events !== 16'd1) begin
      bad++; $display("FAIL lu_events: got %0d want 1", stall_events);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rd_zero();
    do_reset();
    drive_lu(3'd0);
    id_rs2 = 3'd0;
    #3;
    total++;
    if (stall !== 1'b0 || pc_we !== 1'b1) begin
      bad++; $display("FAIL rd_zero: stall=%b pc_we=%b want 0/1", stall, pc_we);
    end
    @(posedge clk); #1;
    total++;
    if (stall_events !== 16'd0) begin
      bad++; $display("FAIL rd_zero_events: got %0d want 0", stall_events);
    end
  endtask

  task automatic test_mul();
    logic       exp_stall [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp_busy  [4] = '{4'd0, 4'd2, 4'd1, 4'd0};
    do_reset();
    id_is_mul = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      total++;
      if (stall !== exp_stall[c] || busy_cnt !== exp_busy[c]) begin
        bad++; $display("FAIL mul_seq[%0d]: stall=%b busy_cnt=%0d want %b/%0d",
                        c, stall, busy_cnt, exp_stall[c], exp_busy[c]);
      end
      @(posedge clk); #1;
      id_is_mul = 1'b0;
    end
    total++;
    if (stall_events !== 16'd2) begin
      bad++; $display("FAIL mul_events: got %0d want 2", stall_events);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    drive_lu(3'd3);
    id_is_mul = 1'b1; branch_taken = 1'b1;
    #3;
    total++;
    if ({flush, stall, pc_we, if_id_we} !== 4'b1011) begin
      bad++; $display("FAIL br_prio: got %b want 1011", {flush, stall, pc_we, if_id_we});
    end
    @(posedge clk); #1;
    drive_idle();
    #3;
    total++;
    if (stall !== 1'b0 || busy_cnt !== 4'd0) begin
      bad++; $display("FAIL br_stay_run: stall=%b busy_cnt=%0d want 0/0", stall, busy_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_branch_in_busy();
    do_reset();
    id_is_mul = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    branch_taken = 1'b1;
    protocol_errs++;
    $display("protocol error: branch_taken during multiply busy (expected to be ignored)");
    #3;
    total++;
    if ({stall, flush, pc_we} !== 3'b100) begin
      bad++; $display("FAIL br_in_busy: got %b want 100", {stall, flush, pc_we});
    end
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    id_is_mul = 1'b1;
    @(posedge clk); #1;
    id_is_mul = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy_cnt !== 4'd1 || stall !== 1'b1) begin
      bad++; $display("FAIL abort_setup: busy_cnt=%0d stall=%b want 1/1", busy_cnt, stall);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({stall, flush, pc_we, if_id_we} !== 4'b0011 || busy_cnt !== 4'd0 || stall_events !== 16'd0) begin
      bad++; $display("FAIL abort_async: ctrl=%b busy_cnt=%0d events=%0d want 0011/0/0",
                      {stall, flush, pc_we, if_id_we}, busy_cnt, stall_events);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #3;
    total++;
    if (stall !== 1'b0 || busy_cnt !== 4'd0) begin
      bad++; $display("FAIL abort_after: stall=%b busy_cnt=%0d want 0/0", stall, busy_cnt);
    end
    #1;
  endtask

  task automatic test_random();
    logic es, ef, ep, ei;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      id_rs1 = RA_W'($urandom_range(0, 3)); id_rs2 = RA_W'($urandom_range(0, 3));
      ex_rd  = RA_W'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_mem_read = 1'($urandom); ex_reg_write = 1'($urandom);
      id_is_mul = ($urandom_range(0, 5) == 0);
      branch_taken = (m_busy == 0) && ($urandom_range(0, 7) == 0);
      model_outputs(es, ef, ep, ei);
      model_next();
      #3;
      total++;
      if ({stall, flush, pc_we, if_id_we} !== {es, ef, ep, ei} || busy_cnt !== 4'(m_busy)) begin
        bad++; $display("FAIL rand_ctrl[%0d]: ctrl=%b busy=%0d want %b/%0d", n,
                        {stall, flush, pc_we, if_id_we}, busy_cnt, {es, ef, ep, ei}, m_busy);
      end
      @(posedge clk);
      m_busy = n_busy; m_events = n_events;
      #1;
      total++;
      if (stall_events !== 16'(m_events)) begin
        bad++; $display("FAIL rand_events[%0d]: got %0d want %0d", n, stall_events, m_events);
      end
    end
    drive_idle();
    repeat (MUL_LAT) @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    drive_lu(3'd3);
    repeat (65534) @(posedge clk);
    #1;
    total++;
    if (stall_events !== 16'hFFFE) begin
      bad++; $display("FAIL sat_near: got %h want fffe", stall_events);
    end
    repeat (70000 - 65534) @(posedge clk);
    #1;
    total++;
    if (stall_events !== 16'hFFFF || stall !== 1'b1) begin
      bad++; $display("FAIL sat_hold: events=%h stall=%b want ffff/1", stall_events, stall);
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_mul();
    test_branch_priority();
    test_branch_in_busy();
    test_reset_mid_busy();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
